// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an external 8:1 selector: steps sel 0..7, waits SETTLE
// extra cycles per step, samples y_in and presents the rebuilt 8-bit word.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       y_in,
    output logic [2:0] sel,
    output logic       busy,
    output logic       done,
    output logic [7:0] data
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    logic [0:0] state;
    logic [3:0] wcnt;
    logic [7:0] shadow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            data   <= '0;
            wcnt   <= '0;
            shadow <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel    <= '0;
                        wcnt   <= '0;
                        shadow <= '0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        sel   <= '0;
                        wcnt  <= '0;
                    end else if (wcnt < SETTLE_CNT) begin
                        wcnt <= wcnt + 4'd1;
                    end else begin
                        shadow[sel] <= y_in;
                        wcnt        <= '0;
                        if (sel == 3'd7) begin
                            // shadow[7] is written this same edge, so take bit 7 straight from y_in
                            data  <= {y_in, shadow[6:0]};
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            sel   <= '0;
                            state <= IDLE;
                        end else begin
                            sel <= sel + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sel   <= '0;
                    wcnt  <= '0;
                end
            endcase
        end
    end

endmodule
